tape_in_conditioner: RTL
========================

// Module: tape_in_conditioner
// PURPOSE
//  Cleans the raw cassette signal (UART_RX pin, asynchronous) before it reaches the Oric core's TAPE_IN.
//  Stages: 2-FF synchroniser, then glitch filter, then edge strobe and activity-LED stretcher.
//  Optional half-period meter classifies each filtered half-cycle as short (1-bit tone) or long (0-bit tone).
//  Sits between the top-level pin and the core's tape input; feeds LED when tape is active.
// PARAMETERS
//  FILTER_CYCLES    48       clocks the synced input must differ from tape_out before it is accepted (2 us @ 24 MHz)
//  ACT_HOLD_CYCLES  2400000  activity stretch after last edge (100 ms @ 24 MHz)
//  CNT_W            16       half-period counter width
//  SHORT_MAX        3744     half-period (clocks) below which period_short=1 (156 us @ 24 MHz)
// PORTS
//  clk_sys       in   1      system clock; all logic on rising edge
//  reset         in   1      synchronous, active-high
//  tape_in_raw   in   1      raw asynchronous tape level from pin
//  tape_out      out  1      filtered tape level to core TAPE_IN
//  edge_stb      out  1      1-clock pulse on every tape_out transition
//  activity      out  1      high while an edge occurred within the last ACT_HOLD_CYCLES clocks
//  period        out  CNT_W  clocks between the last two filtered edges
//  period_vld    out  1      1-clock pulse: period and period_short are updated
//  period_short  out  1      period < SHORT_MAX
// BEHAVIOUR
//  Reset: sync FFs, tape_out, edge_stb, activity, period, period_vld and period_short are all 0; counters are cleared.
//   Reset applied mid-operation aborts everything in flight; no pulse is emitted in the cycle after reset.
//  Sync: s1<=tape_in_raw; s2<=s1. No logic reads s1.
//  Filter: flt_cnt increments while s2!=tape_out and clears to 0 in any cycle where s2==tape_out.
//   When s2!=tape_out and flt_cnt==FILTER_CYCLES-1: tape_out<=s2, edge_stb<=1 (next cycle only), flt_cnt<=0.
//   Latency: a raw change held stable gives a tape_out change FILTER_CYCLES+2 clocks later.
//   A raw pulse shorter than FILTER_CYCLES clocks gives no output change.
//  Activity: act_cnt loads ACT_HOLD_CYCLES on edge_stb and otherwise decrements to 0, saturating; activity=(act_cnt!=0).
//   An edge during hold reloads act_cnt (retrigger). activity rises the cycle after edge_stb.
//  Arithmetic: all counters unsigned. act_cnt width is $clog2(ACT_HOLD_CYCLES+1). No counter wraps.
// CONFIGURATION
//  Macro TAPE_PERIOD_MEAS_EN, when defined:
//   per_cnt increments every clock and saturates at 2^CNT_W-1; saturation sets ovf.
//   armed=0 after reset. On edge_stb:
//    if armed and !ovf: period<=per_cnt, period_short<=(per_cnt<SHORT_MAX), period_vld<=1 the next cycle;
//    per_cnt<=1, ovf<=0, armed<=1.
//   So the first edge after reset or after an overflow only arms; it gives no period_vld.
//   period and period_short hold their values between pulses.
//   If edge_stb and saturation fall in the same cycle, the edge wins: no vld, counter restarts.
//  Macro not defined: period, period_vld and period_short are tied to 0; no counter logic is built.
// TESTING (bench overrides ACT_HOLD_CYCLES=1000; other parameters stay at defaults)
//  1 Hold raw=1 through a 3-cycle reset, then release -> all outputs 0 during reset;
//    tape_out=1 exactly 50 clocks after release; one edge_stb.
//  2 Raw 0->1 pulse of 47 clocks, then 48 clocks -> first: no tape_out change, no edge_stb;
//    second: tape_out pulse of 48 clocks, 2 edge_stbs.
//  3 (MEAS_EN) Square wave with 2496-clock halves -> first edge gives no vld;
//    then period=2496, period_short=1 per edge. With 4992-clock halves: period=4992, period_short=0.
//  4 One edge, then idle -> activity high 1000 clocks, then 0; a second edge at clock 600 keeps it high until 1600.
//  5 (MEAS_EN) Idle >65535 clocks between edges -> next edge gives no vld; the following edge gives a valid period.
//  6 Assert reset mid-filter (flt_cnt=30) and mid-period -> no edge_stb or vld after release; first edge only re-arms.

Source files
------------

// File: rtl/tape_in_conditioner.sv
// Cassette input conditioner: synchroniser, glitch filter, edge strobe, activity stretcher.
// Optional half-period meter built when TAPE_PERIOD_MEAS_EN is defined.
module tape_in_conditioner #(
  parameter int FILTER_CYCLES   = 48,
  parameter int ACT_HOLD_CYCLES = 2400000,
  parameter int CNT_W           = 16,
  parameter int SHORT_MAX       = 3744
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             tape_in_raw,
  output logic             tape_out,
  output logic             edge_stb,
  output logic             activity,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             period_short
);

  localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
  localparam int ACT_W = $clog2(ACT_HOLD_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);
  localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_HOLD_CYCLES);

  logic             s1;
  logic             s2;
  logic [FLT_W-1:0] flt_cnt;
  logic [ACT_W-1:0] act_cnt;

  // Synchroniser and glitch filter: tape_out only follows s2 after a stable run.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      flt_cnt  <= '0;
      tape_out <= 1'b0;
      edge_stb <= 1'b0;
    end else begin
      s1       <= tape_in_raw;
      s2       <= s1;
      edge_stb <= 1'b0;
      if (s2 == tape_out) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        tape_out <= s2;
        edge_stb <= 1'b1;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // Activity stretcher, retriggered by every filtered edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      act_cnt <= '0;
    end else if (edge_stb) begin
      act_cnt <= ACT_LOAD;
    end else if (act_cnt != '0) begin
      act_cnt <= act_cnt - 1'b1;
    end
  end

  assign activity = (act_cnt != '0);

`ifdef TAPE_PERIOD_MEAS_EN
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(SHORT_MAX);

  logic [CNT_W-1:0] per_cnt;
  logic             ovf;
  logic             armed;

  // Half-period meter: an overflowed or unarmed interval only re-arms.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      per_cnt      <= '0;
      ovf          <= 1'b0;
      armed        <= 1'b0;
      period       <= '0;
      period_vld   <= 1'b0;
      period_short <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (edge_stb) begin
        if (armed && !ovf) begin
          period       <= per_cnt;
          period_short <= (per_cnt < SHORT_LIM);
          period_vld   <= 1'b1;
        end
        per_cnt <= CNT_W'(1);
        ovf     <= 1'b0;
        armed   <= 1'b1;
      end else if (per_cnt != CNT_MAX) begin
        per_cnt <= per_cnt + 1'b1;
        if (per_cnt == CNT_MAX - 1'b1) ovf <= 1'b1;
      end
    end
  end
`else
  assign period       = '0;
  assign period_vld   = 1'b0;
  assign period_short = 1'b0;
`endif

endmodule
